// File: rtl/d5m_stream_gen.sv
// Synthetic D5M sensor source: 12-bit raw pixels with FVAL/LVAL framing,
// deterministic test patterns and a running count of completed frames.
module d5m_stream_gen #(
  parameter int H_ACTIVE    = 1280,
  parameter int H_BLANK     = 384,
  parameter int V_ACTIVE    = 960,
  parameter int V_BLANK     = 4096,
  parameter int F_PRE       = 64,
  parameter int F_POST      = 64,
  parameter int CHECK_SHIFT = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic        iSTOP,
  input  logic [1:0]  iMODE,
  input  logic [11:0] iCONST,
  output logic [11:0] oD,
  output logic        oFVAL,
  output logic        oLVAL,
  output logic [31:0] oFrame_Cont,
  output logic        oBUSY
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_LINE = 3'd2,
    ST_HBLK = 3'd3,
    ST_POST = 3'd4,
    ST_VBLK = 3'd5
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] cnt_r, cnt_s;
  logic [15:0] x_r, x_s, y_r, y_s;
  logic [1:0]  mode_r, mode_s;
  logic [11:0] const_r, const_s;
  logic [3:0]  tag_r, tag_s;
  logic [31:0] frame_cnt_r, frame_cnt_s;
  logic        stop_r, stop_s;
  logic [11:0] d_s;
  logic        fval_s, lval_s, busy_s;

  function automatic logic [11:0] pattern(input logic [1:0]  mode,
                                          input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic [11:0] cval,
                                          input logic [3:0]  tag);
    case (mode)
      2'd0:    pattern = 12'(x + y);
      2'd1:    pattern = ((((x ^ y) >> CHECK_SHIFT) & 16'd1) != 16'd0) ? 12'hFFF : 12'h000;
      2'd2:    pattern = cval;
      2'd3:    pattern = {tag, x[7:0]};
      default: pattern = 12'h000;
    endcase
  endfunction

  // State, counters, latched frame settings and registered outputs.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 32'd0;
      x_r         <= 16'd0;
      y_r         <= 16'd0;
      mode_r      <= 2'd0;
      const_r     <= 12'h000;
      tag_r       <= 4'd0;
      frame_cnt_r <= 32'd0;
      stop_r      <= 1'b0;
      oD          <= 12'h000;
      oFVAL       <= 1'b0;
      oLVAL       <= 1'b0;
      oBUSY       <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      x_r         <= x_s;
      y_r         <= y_s;
      mode_r      <= mode_s;
      const_r     <= const_s;
      tag_r       <= tag_s;
      frame_cnt_r <= frame_cnt_s;
      stop_r      <= stop_s;
      oD          <= d_s;
      oFVAL       <= fval_s;
      oLVAL       <= lval_s;
      oBUSY       <= busy_s;
    end
  end

  // Next-state, counter and frame-setting logic.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    x_s         = x_r;
    y_s         = y_r;
    mode_s      = mode_r;
    const_s     = const_r;
    tag_s       = tag_r;
    frame_cnt_s = frame_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (iSTART && !iSTOP) begin
          state_s = ST_PRE;
          cnt_s   = 32'd0;
          mode_s  = iMODE;
          const_s = iCONST;
          tag_s   = frame_cnt_r[3:0];
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PRE: begin
        if (cnt_r == 32'(F_PRE - 1)) begin
          state_s = ST_LINE;
          x_s     = 16'd0;
          y_s     = 16'd0;
        end else begin
          cnt_s = cnt_r + 32'd1;
        end
      end
      ST_LINE: begin
        if (x_r == 16'(H_ACTIVE - 1)) begin
          cnt_s = 32'd0;
          if (y_r == 16'(V_ACTIVE - 1)) begin
            state_s = ST_POST;
          end else begin
            state_s = ST_HBLK;
          end
        end else begin
          x_s = x_r + 16'd1;
        end
      end
      ST_HBLK: begin
        if (cnt_r == 32'(H_BLANK - 1)) begin
          state_s = ST_LINE;
          x_s     = 16'd0;
          y_s     = y_r + 16'd1;
        end else begin
          cnt_s = cnt_r + 32'd1;
        end
      end
      ST_POST: begin
        if (cnt_r == 32'(F_POST - 1)) begin
          state_s     = ST_VBLK;
          cnt_s       = 32'd0;
          frame_cnt_s = frame_cnt_r + 32'd1;
        end else begin
          cnt_s = cnt_r + 32'd1;
        end
      end
      ST_VBLK: begin
        if (cnt_r == 32'(V_BLANK - 1)) begin
          cnt_s = 32'd0;
          if (stop_r) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_PRE;
            mode_s  = iMODE;
            const_s = iCONST;
            tag_s   = frame_cnt_r[3:0];
          end
        end else begin
          cnt_s = cnt_r + 32'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 32'd0;
      end
    endcase
    // A pending stop clears on reaching IDLE; otherwise any stop while streaming sticks.
    if ((state_r != ST_IDLE) && (state_s == ST_IDLE)) begin
      stop_s = 1'b0;
    end else if (iSTOP && (state_r != ST_IDLE)) begin
      stop_s = 1'b1;
    end else begin
      stop_s = stop_r;
    end
  end

  // Output values for the state being entered, so outputs move with the state register.
  always_comb begin
    d_s    = 12'h000;
    fval_s = 1'b0;
    lval_s = 1'b0;
    busy_s = (state_s != ST_IDLE);
    case (state_s)
      ST_PRE, ST_HBLK, ST_POST: begin
        fval_s = 1'b1;
      end
      ST_LINE: begin
        fval_s = 1'b1;
        lval_s = 1'b1;
        d_s    = pattern(mode_s, x_s, y_s, const_s, tag_s);
      end
      ST_IDLE, ST_VBLK: begin
        fval_s = 1'b0;
      end
      default: begin
        fval_s = 1'b0;
      end
    endcase
  end

  assign oFrame_Cont = frame_cnt_r;

endmodule

// File: tb/tb_d5m_stream_gen.sv
// Self-checking bench for d5m_stream_gen: a timeline-based reference model
// predicts every output each cycle under directed and random stimulus.
module tb_d5m_stream_gen;

  localparam int HA   = 8;
  localparam int HB   = 4;
  localparam int VA   = 4;
  localparam int VB   = 6;
  localparam int FPRE = 2;
  localparam int FPST = 2;
  localparam int CS   = 2;
  localparam int FH   = FPRE + VA * HA + (VA - 1) * HB + FPST;
  localparam int FP   = FH + VB;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iSTART = 1'b0;
  logic        iSTOP = 1'b0;
  logic [1:0]  iMODE = 2'd0;
  logic [11:0] iCONST = 12'h000;
  logic [11:0] oD;
  logic        oFVAL, oLVAL, oBUSY;
  logic [31:0] oFrame_Cont;

  always #5 iCLK = ~iCLK;

  d5m_stream_gen #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
    .F_PRE(FPRE), .F_POST(FPST), .CHECK_SHIFT(CS)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iSTOP(iSTOP),
    .iMODE(iMODE), .iCONST(iCONST), .oD(oD), .oFVAL(oFVAL),
    .oLVAL(oLVAL), .oFrame_Cont(oFrame_Cont), .oBUSY(oBUSY)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame position m_t counts cycles since the frame's first FVAL cycle.
  bit          m_active = 1'b0;
  bit          m_stop = 1'b0;
  int          m_t = 0;
  logic [31:0] m_frames = 32'd0;
  logic [1:0]  m_mode = 2'd0;
  logic [11:0] m_const = 12'h000;
  logic [3:0]  m_tag = 4'd0;
  bit          rst_edge = 1'b0;

  int fval_run = 0;
  int lval_run = 0;
  int gap_run = 0;
  bit after_line = 1'b0;

  task automatic latch_frame();
    m_mode  = iMODE;
    m_const = iCONST;
    m_tag   = m_frames[3:0];
  endtask

  task automatic model_step();
    int nt;
    bit going_idle;
    going_idle = 1'b0;
    if (iRST) begin
      m_active = 1'b0; m_stop = 1'b0; m_t = 0; m_frames = 32'd0;
      m_mode = 2'd0; m_const = 12'h000; m_tag = 4'd0;
    end else if (!m_active) begin
      if (iSTART && !iSTOP) begin
        m_active = 1'b1;
        m_t = 0;
        latch_frame();
      end
    end else begin
      nt = m_t + 1;
      if (nt == FH) m_frames = m_frames + 32'd1;
      if (nt == FP) begin
        nt = 0;
        if (m_stop) begin
          m_active = 1'b0;
          m_stop = 1'b0;
          going_idle = 1'b1;
        end else begin
          latch_frame();
        end
      end
      if (iSTOP && !going_idle) m_stop = 1'b1;
      m_t = nt;
    end
  endtask

  function automatic logic [11:0] exp_pix(input int x, input int y);
    case (m_mode)
      2'd0:    return 12'((x + y) % 4096);
      2'd1:    return ((((x >> CS) ^ (y >> CS)) & 1) == 1) ? 12'hFFF : 12'h000;
      2'd2:    return m_const;
      default: return 12'((int'(m_tag) << 8) | (x & 255));
    endcase
  endfunction

  task automatic compare_all();
    bit ef, el;
    logic [11:0] ed;
    int u;
    ef = m_active && (m_t < FH);
    el = 1'b0;
    ed = 12'h000;
    u  = m_t - FPRE;
    if (ef && u >= 0 && u < VA * (HA + HB) - HB) begin
      if ((u % (HA + HB)) < HA) begin
        el = 1'b1;
        ed = exp_pix(u % (HA + HB), u / (HA + HB));
      end
    end
    check("fval", oFVAL, ef);
    check("lval", oLVAL, el);
    check("data", oD, ed);
    check("busy", oBUSY, m_active);
    check("frame_cont", oFrame_Cont, m_frames);
    check("lval_implies_fval", oLVAL & ~oFVAL, 1'b0);
    // Run-length checks on the waveform itself; runs cut short by reset are skipped.
    if (oFVAL) begin
      fval_run++;
    end else begin
      if (fval_run != 0 && !rst_edge) check("fval_len", fval_run, FH);
      fval_run = 0;
      after_line = 1'b0;
    end
    if (oLVAL) begin
      if (after_line && gap_run > 0) check("lval_gap", gap_run, HB);
      gap_run = 0;
      lval_run++;
    end else begin
      if (lval_run != 0 && !rst_edge) begin
        check("lval_len", lval_run, HA);
        after_line = oFVAL;
      end
      lval_run = 0;
      if (after_line) gap_run++;
      else gap_run = 0;
    end
    if (rst_edge) begin
      fval_run = 0; lval_run = 0; gap_run = 0; after_line = 1'b0;
    end
  endtask

  task automatic tick();
    rst_edge = iRST;
    @(posedge iCLK);
    model_step();
    @(negedge iCLK);
    compare_all();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && oBUSY; i++) tick();
    check(tag, oBUSY, 1'b0);
  endtask

  initial begin
    // Reset
    repeat (3) tick();
    iRST = 1'b0;
    check("rst_d", oD, 12'h000);
    check("rst_fcnt", oFrame_Cont, 32'd0);
    check("rst_busy", oBUSY, 1'b0);
    tick();

    // Ramp frame, then checker, then constant with a stop inside the third frame
    iMODE = 2'd0;
    iSTART = 1'b1;
    tick();
    iSTART = 1'b0;
    check("start_fval", oFVAL, 1'b1);
    check("start_busy", oBUSY, 1'b1);
    repeat (20) tick();
    iMODE = 2'd1;
    repeat (FP) tick();
    iMODE = 2'd2;
    iCONST = 12'hA5A;
    repeat (FP) tick();
    iSTOP = 1'b1;
    tick();
    iSTOP = 1'b0;
    wait_idle("stop_idle", 4 * FP);
    check("stop_fcnt", oFrame_Cont, 32'd3);
    repeat (10) tick();
    check("stop_no_fval", oFVAL, 1'b0);

    // Start and stop together in IDLE: stop wins
    iSTART = 1'b1;
    iSTOP = 1'b1;
    tick();
    iSTART = 1'b0;
    iSTOP = 1'b0;
    check("both_fval", oFVAL, 1'b0);
    check("both_busy", oBUSY, 1'b0);
    repeat (5) tick();

    // Reset in the middle of line 2
    iMODE = 2'd0;
    iSTART = 1'b1;
    tick();
    iSTART = 1'b0;
    repeat (27) tick();
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    check("mrst_fval", oFVAL, 1'b0);
    check("mrst_lval", oLVAL, 1'b0);
    check("mrst_d", oD, 12'h000);
    check("mrst_fcnt", oFrame_Cont, 32'd0);
    iSTART = 1'b1;
    tick();
    iSTART = 1'b0;
    repeat (FP + 4) tick();

    // Frame-tag mode across 17 frames so the tag wraps
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    iMODE = 2'd3;
    iSTART = 1'b1;
    tick();
    iSTART = 1'b0;
    repeat (16 * FP + 20) tick();
    iSTOP = 1'b1;
    tick();
    iSTOP = 1'b0;
    wait_idle("tag_idle", 2 * FP);
    check("tag_fcnt", oFrame_Cont, 32'd17);

    // Random stimulus
    for (int i = 0; i < 1500; i++) begin
      iRST   = ($urandom_range(0, 299) == 0);
      iSTART = ($urandom_range(0, 7) == 0);
      iSTOP  = ($urandom_range(0, 59) == 0);
      iMODE  = 2'($urandom_range(0, 3));
      iCONST = 12'($urandom);
      tick();
    end
    iRST = 1'b0;
    iSTART = 1'b0;
    iSTOP = 1'b1;
    tick();
    iSTOP = 1'b0;
    wait_idle("final_idle", 2 * FP);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/d5m_stream_gen.md
Name: d5m_stream_gen

Overview:
- Synthetic D5M sensor source. Emits 12-bit raw pixel data with FVAL/LVAL framing, the same waveform the camera capture path receives from the sensor.
- Used on-board as a camera-less bypass into the capture/RAW2RGB/SDRAM chain, and in simulation as the stimulus source for capture-path benches.
- Generates deterministic test patterns and maintains its own frame count.

Parameters:
- H_ACTIVE, 1280, pixels per line (LVAL-high cycles).
- H_BLANK, 384, LVAL-low cycles between lines within a frame (must be ≥1).
- V_ACTIVE, 960, lines per frame.
- V_BLANK, 4096, FVAL-low cycles between frames (must be ≥1).
- F_PRE, 64, FVAL-high/LVAL-low cycles before the first line (must be ≥1).
- F_POST, 64, FVAL-high/LVAL-low cycles after the last line (must be ≥1).
- CHECK_SHIFT, 4, log2 of the checkerboard square size.

Ports:
- iCLK, in, 1, pixel clock.
- iRST, in, 1, synchronous reset, active-high.
- iSTART, in, 1, level/pulse: begin streaming.
- iSTOP, in, 1, level/pulse: stop after the current frame.
- iMODE, in, 2, pattern select: 0 ramp, 1 checker, 2 constant, 3 frame-tag.
- iCONST, in, 12, pixel value for mode 2.
- oD, out, 12, pixel data.
- oFVAL, out, 1, frame valid.
- oLVAL, out, 1, line valid.
- oFrame_Cont, out, 32, count of completed frames.
- oBUSY, out, 1, high whenever state ≠ IDLE.

Behaviour:
- Clock and reset: one clock, iCLK. Reset iRST is synchronous, active-high.
- Register timing: all outputs are flops updated on the same edge as the state register. No combinational path from any input to any output.
- Reset: state=IDLE; oD=0, oFVAL=0, oLVAL=0, oFrame_Cont=0, oBUSY=0; stop_pending=0; X/Y counters=0.
- Reset mid-frame: same as above, applied on the next edge; the frame is abandoned and oFVAL drops immediately.
- States: IDLE, PRE, LINE, HBLK, POST, VBLK.
- IDLE:
  - iSTART=1 and iSTOP=0 → PRE, with oFVAL=1 and oBUSY=1 from that edge.
  - iSTART and iSTOP both 1 → stay IDLE (stop has priority).
- PRE: F_PRE cycles with FVAL=1, LVAL=0, then → LINE with X=0, Y=0.
- LINE:
  - H_ACTIVE cycles with LVAL=1; oD = pattern(X,Y); X increments each cycle.
  - At X=H_ACTIVE-1: if Y=V_ACTIVE-1 → POST, else → HBLK.
- HBLK: H_BLANK cycles with LVAL=0, oD=0; then Y+1, X=0 → LINE.
- POST: F_POST cycles with FVAL=1, LVAL=0.
- POST → VBLK: on this edge oFVAL falls and oFrame_Cont increments by 1 (wraps at 2^32).
- VBLK: V_BLANK cycles with FVAL=0.
  - Then if stop_pending=1 → IDLE, clearing stop_pending and oBUSY.
  - Otherwise → PRE.
- Frame geometry:
  - FVAL-high length = F_PRE + V_ACTIVE·H_ACTIVE + (V_ACTIVE−1)·H_BLANK + F_POST.
  - Frame period = FVAL-high length + V_BLANK.
- oD outside LINE: 0.
- iSTART while not IDLE: ignored.
- iSTOP while not IDLE: sets stop_pending; it is sticky until IDLE is reached. Frames are never truncated.
- iMODE and iCONST: latched on entry to PRE and held for the whole frame. Mid-frame changes take effect at the next frame.
- Patterns (12-bit, modulo 4096); X, Y are active-pixel coordinates from 0:
  - mode 0: (X + Y) mod 4096.
  - mode 1: 12'hFFF if ((X>>CHECK_SHIFT) ^ (Y>>CHECK_SHIFT)) bit0 = 1, else 12'h000.
  - mode 2: latched iCONST.
  - mode 3: {oFrame_Cont[3:0], X[7:0]}, using the count value at frame start.
- Counter widths: X and Y are 16-bit minimum; parameters must fit.
- Timing guarantee: LVAL never high while FVAL is low. Every LVAL-high run is exactly H_ACTIVE cycles.

Test Plan:
Bench parameters: H_ACTIVE=8, H_BLANK=4, V_ACTIVE=4, V_BLANK=6, F_PRE=2, F_POST=2, CHECK_SHIFT=2.
1. Reset, 1-cycle iSTART, mode 0:
   - oFVAL high exactly 48 cycles from the edge after the iSTART sample.
   - 4 LVAL runs of 8 cycles each, 4-cycle gaps between runs.
   - Line 2 data = 2,3,…,9.
   - oFrame_Cont=1 on the edge FVAL falls; next FVAL rises 6 cycles later.
2. Mode 1: every line, X0–3 = 000 and X4–7 = FFF. Mode 2 with iCONST=12'hA5A: all 32 active pixels = A5A.
3. Change iMODE 0→2 during frame 1 (mode 0 latched at its start) → frame 1 entirely ramp; frame 2 entirely constant.
4. Pulse iSTOP mid-line in frame 3:
   - Frame 3 completes all 32 pixels; oFrame_Cont=3.
   - IDLE after the 6 VBLK cycles, oBUSY=0.
   - No further FVAL.
   - Simultaneous iSTART+iSTOP in IDLE → no FVAL.
5. Assert iRST during line 2 → next edge: oFVAL=oLVAL=0, oD=0, oFrame_Cont=0. A new iSTART yields a full 48-cycle frame.
6. Mode 3 over 17 continuous frames:
   - Frame n pixel X=5 = {n[3:0], 8'h05}.
   - Frame 16 pixel X=5 = 12'h005.
   - Assertion throughout: LVAL ⇒ FVAL.
